vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates the raster counters and sync signals that every sprite/overlay controller in the VGA path consumes (hCount, vCount, bright), plus hSync/vSync for the connector. It runs from the 100 MHz system clock with an internal pixel-tick divider. It also provides sync and bright outputs delayed by a programmable number of system clocks, so they line up with overlay controllers whose synchronous sprite ROM adds one clock of colour latency.

Parameters:
CLK_DIV, 4, system clocks per pixel; power of two, 2..16
H_TOTAL, 800, pixels per line, counts 0..H_TOTAL-1
H_SYNC, 96, hSync low while hCount < H_SYNC
H_ACT_START, 144, first visible hCount
H_ACT_END, 784, first non-visible hCount after the active region
V_TOTAL, 525, lines per frame
V_SYNC, 2, vSync low while vCount < V_SYNC
V_ACT_START, 35, first visible vCount
V_ACT_END, 515, first non-visible vCount after the active region
SYNC_DLY, 1, system-clock delay applied to the *_d outputs; 0..3

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous active-high reset
hCount  out  10  horizontal pixel counter
vCount  out  10  vertical line counter
bright  out  1  high when the pixel is inside both active windows
hSync  out  1  horizontal sync, active low
vSync  out  1  vertical sync, active low
pix_tick  out  1  one-clk pulse on the clock where the counters advance
line_start  out  1  one-clk pulse coincident with pix_tick when hCount wraps to 0
frame_start  out  1  one-clk pulse coincident with pix_tick when hCount and vCount both wrap to 0
frame_cnt  out  16  frames completed since reset, wraps at 0xFFFF->0
hSync_d  out  1  hSync delayed SYNC_DLY clks
vSync_d  out  1  vSync delayed SYNC_DLY clks
bright_d  out  1  bright delayed SYNC_DLY clks

Behaviour:
- Everything is synchronous to clk. rst is sampled only on a rising edge of clk.
- Reset values: div counter 0, hCount 0, vCount 0, frame_cnt 0, pix_tick/line_start/frame_start 0, hSync 0, vSync 0, bright 0. Every stage of the delay lines is cleared, so hSync_d, vSync_d and bright_d are 0 during reset.
- Divider: counts 0..CLK_DIV-1 and wraps.
  - pix_tick is registered high on the clk after the divider reaches CLK_DIV-1.
  - After rst deasserts, the first pix_tick occurs CLK_DIV clks later. Period is exactly CLK_DIV clks.
- On a pix_tick clock:
  - hCount increments. At H_TOTAL-1 it wraps to 0.
  - When hCount wraps, vCount increments. At V_TOTAL-1 vCount wraps to 0, and frame_cnt increments in the same clock.
- Counters hold their value between ticks.
- line_start and frame_start are each one clk wide and occur only with pix_tick.
- hSync, vSync and bright are registered decodes of the new counter values. They change in the same clock as the counters: no skew between counters and decodes.
  - hSync = !(hCount < H_SYNC)
  - vSync = !(vCount < V_SYNC)
  - bright = H_ACT_START <= hCount < H_ACT_END and V_ACT_START <= vCount < V_ACT_END
- Delay lines: shift registers of depth SYNC_DLY, updated every clk (not every tick). With SYNC_DLY=0, the *_d outputs equal the undelayed outputs combinationally.
- Reset mid-line or mid-frame: all state returns to reset values on the next edge. There is no partial-frame recovery, and frame_cnt restarts at 0.
- rst held high: counters stay frozen at 0 and no pulses are generated.
- Width rule: H_TOTAL and V_TOTAL must be ≤1024. Comparisons are unsigned 10-bit.

Test Plan:
- Reset release: assert rst 5 clks, then release -> hCount=vCount=0, hSync=vSync=0, bright=0. First pix_tick at clk 4 after release, hCount=1 after it. Ticks every 4 clks thereafter.
- Line wrap: run to hCount=799 -> next tick gives hCount=0, vCount+1, line_start=1 for exactly one clk. hSync is low for hCount 0..95 and high at 96. Line period is 3200 clks.
- Active window: scan one frame -> bright=1 only for hCount 144..783 and vCount 35..514. First bright at (144,35), last at (783,514). Count of bright ticks = 640×480 = 307200.
- Frame wrap: run 2 frames -> frame_start pulses at (0,0), 1,680,000 clks apart. vSync low for vCount 0..1. frame_cnt reads 1, then 2. Force frame_cnt to 0xFFFF -> it wraps to 0.
- Delay alignment (SYNC_DLY=1): bright_d equals bright of the previous clk. Check cycle-accurately over a bright rising and falling edge. Repeat with SYNC_DLY=0 -> bright_d==bright every clk.
- Mid-frame reset: pulse rst for 1 clk at (400,300) -> next clk counters=0, frame_cnt=0, and *_d all 0. The normal sequence then resumes.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/bright decodes and clock-delayed sync copies.
// Pixel clock is derived from the system clock by an internal divider.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int SYNC_DLY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        hSync,
    output logic        vSync,
    output logic        pix_tick,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        hSync_d,
    output logic        vSync_d,
    output logic        bright_d
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] r_div;
    logic [9:0]    r_h, r_v;
    logic [15:0]   r_fc;
    logic          r_hs, r_vs, r_br, r_pt, r_ls, r_fs;
    logic          w_tick, w_h_wrap, w_v_wrap;
    logic [9:0]    w_h_nxt, w_v_nxt;

    assign w_tick   = r_div == DW'(CLK_DIV - 1);
    assign w_h_wrap = r_h == 10'(H_TOTAL - 1);
    assign w_v_wrap = r_v == 10'(V_TOTAL - 1);
    assign w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
    assign w_v_nxt  = !w_h_wrap ? r_v : w_v_wrap ? 10'd0 : r_v + 10'd1;

    // Decodes are taken from the next counter values so they land on the same edge as the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
            r_fc  <= '0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_br  <= 1'b0;
            r_pt  <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            r_pt  <= w_tick;
            r_ls  <= w_tick && w_h_wrap;
            r_fs  <= w_tick && w_h_wrap && w_v_wrap;
            if (w_tick) begin
                r_h  <= w_h_nxt;
                r_v  <= w_v_nxt;
                r_hs <= w_h_nxt >= 10'(H_SYNC);
                r_vs <= w_v_nxt >= 10'(V_SYNC);
                r_br <= w_h_nxt >= 10'(H_ACT_START) && w_h_nxt < 10'(H_ACT_END) &&
                        w_v_nxt >= 10'(V_ACT_START) && w_v_nxt < 10'(V_ACT_END);
                if (w_h_wrap && w_v_wrap) r_fc <= r_fc + 16'd1;
            end
        end
    end

    assign hCount      = r_h;
    assign vCount      = r_v;
    assign bright      = r_br;
    assign hSync       = r_hs;
    assign vSync       = r_vs;
    assign pix_tick    = r_pt;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fc;

    generate
        if (SYNC_DLY == 0) begin : g_nodly
            assign {hSync_d, vSync_d, bright_d} = {r_hs, r_vs, r_br};
        end else begin : g_dly
            // Three-bit stages {hs, vs, bright}; the oldest stage sits at the top of w_sh.
            logic [3*SYNC_DLY-1:0] r_dl;
            logic [3*SYNC_DLY+2:0] w_sh;
            assign w_sh = {r_dl, r_hs, r_vs, r_br};
            always_ff @(posedge clk) begin
                if (rst) r_dl <= '0;
                else r_dl <= w_sh[3*SYNC_DLY-1:0];
            end
            assign {hSync_d, vSync_d, bright_d} = w_sh[3*SYNC_DLY+2 -: 3];
        end
    endgenerate
endmodule
